// File: rtl/hart_dcache_tlc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hart_dcache_tlc_sched
//  Description : TileLink channel C scheduler for the hart data cache.
//                Arbitrates ProbeAck(Data) from the probe handler against
//                Release(Data) from the writeback unit, locks the grant for
//                multibeat bursts and tracks the outstanding Release.
//  Revision    : 1.0 - initial release
// ============================================================================
module hart_dcache_tlc_sched #(
    parameter int   MAX_SIZE     = 6,
    parameter int   PROBE_STREAK = 4,
    parameter logic SOURCE_ID    = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic [2:0]  p_opcode,
    input  logic [2:0]  p_param,
    input  logic [3:0]  p_size,
    input  logic [31:0] p_address,
    input  logic [31:0] p_data,
    input  logic        p_corrupt,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [2:0]  r_opcode,
    input  logic [2:0]  r_param,
    input  logic [3:0]  r_size,
    input  logic [31:0] r_address,
    input  logic [31:0] r_data,
    input  logic        r_corrupt,
    input  logic        c_ready,
    output logic        c_valid,
    output logic [2:0]  c_opcode,
    output logic [2:0]  c_param,
    output logic [3:0]  c_size,
    output logic [31:0] c_address,
    output logic [31:0] c_data,
    output logic        c_corrupt,
    output logic        c_source,
    input  logic        d_relack,
    output logic        rel_pending,
    output logic        err
);

    // Beat counter holds up to 2^MAX_SIZE/4 beats (32-bit beats).
    localparam int               c_CNT_W    = MAX_SIZE - 1;
    localparam int               c_STK_W    = $clog2(PROBE_STREAK + 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_STK_W-1:0] c_STREAK = c_STK_W'(PROBE_STREAK);
    localparam logic [3:0]       c_MAX_SIZE = 4'(MAX_SIZE);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BURST_P = 2'd1;
    localparam logic [1:0] c_BURST_R = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_beatCnt;
    logic [c_STK_W-1:0] r_streak;
    logic               r_relPending;
    logic               r_err;
    logic [2:0]         r_burstOpcode;
    logic [3:0]         r_burstSize;

    logic               w_relElig;
    logic               w_grantP;
    logic               w_grantR;
    logic [2:0]         w_opcode;
    logic [3:0]         w_size;
    logic [3:0]         w_sizeClamp;
    logic               w_hasData;
    logic [c_CNT_W-1:0] w_beats;
    logic               w_fire;
    logic               w_last;
    logic               w_msgEnd;
    logic               w_anyErr;

    // Grant selection: priority to probes unless the streak limit is hit; locked in a burst.
    always_comb begin
        w_relElig = r_valid && !r_relPending;
        w_grantP  = 1'b0;
        w_grantR  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_grantP = p_valid && !(w_relElig && (r_streak == c_STREAK));
                w_grantR = w_relElig && !w_grantP;
            end
            c_BURST_P: w_grantP = 1'b1;
            c_BURST_R: w_grantR = 1'b1;
            default: ;
        endcase
        if (reset) begin
            w_grantP = 1'b0;
            w_grantR = 1'b0;
        end
    end

    assign c_valid   = (w_grantP && p_valid) || (w_grantR && r_valid);
    assign p_ready   = w_grantP && c_ready;
    assign r_ready   = w_grantR && c_ready;
    assign c_opcode  = w_grantR ? r_opcode  : p_opcode;
    assign c_param   = w_grantR ? r_param   : p_param;
    assign c_size    = w_grantR ? r_size    : p_size;
    assign c_address = w_grantR ? r_address : p_address;
    assign c_data    = w_grantR ? r_data    : p_data;
    assign c_corrupt = w_grantR ? r_corrupt : p_corrupt;
    assign c_source  = SOURCE_ID;

    assign w_opcode    = c_opcode;
    assign w_size      = c_size;
    assign w_hasData   = w_opcode[0];
    // Oversized messages are flagged as errors; clamping keeps the counter in range.
    assign w_sizeClamp = (w_size > c_MAX_SIZE) ? c_MAX_SIZE : w_size;
    assign w_beats     = (w_hasData && (w_sizeClamp >= 4'd2)) ? (c_ONE << (w_sizeClamp - 4'd2)) : c_ONE;
    assign w_fire      = c_valid && c_ready;
    assign w_last      = (r_state == c_IDLE) ? (w_beats == c_ONE) : (r_beatCnt == c_ONE);
    assign w_msgEnd    = w_fire && w_last;

    assign w_anyErr = (w_fire && w_grantP && (p_opcode[2:1] != 2'b10))
                   || (w_fire && w_grantR && (r_opcode[2:1] != 2'b11))
                   || (w_fire && (r_state != c_IDLE)
                       && ((w_opcode != r_burstOpcode) || (w_size != r_burstSize)))
                   || (w_fire && w_hasData && (w_size > c_MAX_SIZE))
                   || (d_relack && !r_relPending);

    // Burst FSM: load the beat counter on a multibeat first beat, count down to the last beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_beatCnt     <= '0;
            r_burstOpcode <= 3'd0;
            r_burstSize   <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_fire && !w_last) begin
                        r_beatCnt     <= w_beats - c_ONE;
                        r_burstOpcode <= w_opcode;
                        r_burstSize   <= w_size;
                        r_state       <= w_grantR ? c_BURST_R : c_BURST_P;
                    end
                end
                c_BURST_P, c_BURST_R: begin
                    if (w_fire) begin
                        r_beatCnt <= r_beatCnt - c_ONE;
                        if (r_beatCnt == c_ONE) begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Fairness streak, outstanding-Release tracking and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_streak     <= '0;
            r_relPending <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_msgEnd && w_grantR) begin
                r_streak <= '0;
            end else if (w_msgEnd && w_grantP && r_valid) begin
                if (r_streak != c_STREAK) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if ((r_state == c_IDLE) && !r_valid) begin
                r_streak <= '0;
            end
            // A new Release wins over a simultaneous ReleaseAck.
            if (w_msgEnd && w_grantR && (r_opcode[2:1] == 2'b11)) begin
                r_relPending <= 1'b1;
            end else if (d_relack) begin
                r_relPending <= 1'b0;
            end
            if (w_anyErr) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rel_pending = r_relPending;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hart_dcache_tlc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hart_dcache_tlc_sched
//  Description : Self-checking bench for hart_dcache_tlc_sched: table of
//                single-message vectors plus multi-cycle burst sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hart_dcache_tlc_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        p_valid, p_ready, p_corrupt;
    logic [2:0]  p_opcode, p_param;
    logic [3:0]  p_size;
    logic [31:0] p_address, p_data;
    logic        r_valid, r_ready, r_corrupt;
    logic [2:0]  r_opcode, r_param;
    logic [3:0]  r_size;
    logic [31:0] r_address, r_data;
    logic        c_ready, c_valid, c_corrupt, c_source;
    logic [2:0]  c_opcode, c_param;
    logic [3:0]  c_size;
    logic [31:0] c_address, c_data;
    logic        d_relack, rel_pending, err;

    int nTests = 0;
    int nFail  = 0;

    hart_dcache_tlc_sched #(.MAX_SIZE(6), .PROBE_STREAK(4), .SOURCE_ID(1'b0)) dut (
        .clock(clock), .reset(reset),
        .p_valid(p_valid), .p_ready(p_ready), .p_opcode(p_opcode), .p_param(p_param),
        .p_size(p_size), .p_address(p_address), .p_data(p_data), .p_corrupt(p_corrupt),
        .r_valid(r_valid), .r_ready(r_ready), .r_opcode(r_opcode), .r_param(r_param),
        .r_size(r_size), .r_address(r_address), .r_data(r_data), .r_corrupt(r_corrupt),
        .c_ready(c_ready), .c_valid(c_valid), .c_opcode(c_opcode), .c_param(c_param),
        .c_size(c_size), .c_address(c_address), .c_data(c_data), .c_corrupt(c_corrupt),
        .c_source(c_source), .d_relack(d_relack), .rel_pending(rel_pending), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       pv;
        logic [2:0] pop;
        logic [3:0] psz;
        logic       rv;
        logic [2:0] rop;
        logic [3:0] rsz;
        logic       cr;
        logic       ack;
        logic [1:0] src;   // 0 none, 1 probe, 2 release
        logic       pr;
        logic       rr;
        logic       relp;
        logic       er;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        p_valid = 0; p_opcode = 3'd4; p_param = 3'd1; p_size = 4'd0; p_address = 32'h0;
        p_data = 32'h0; p_corrupt = 0;
        r_valid = 0; r_opcode = 3'd6; r_param = 3'd2; r_size = 4'd0; r_address = 32'h0;
        r_data = 32'h0; r_corrupt = 0;
        c_ready = 0; d_relack = 0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        logic fireNow;
        logic [2:0] expOps [6];
        expOps[0] = 3'd4; expOps[1] = 3'd4; expOps[2] = 3'd4;
        expOps[3] = 3'd4; expOps[4] = 3'd6; expOps[5] = 3'd4;

        //            pv pop psz rv rop rsz cr ack src pr rr relp er
        vecs[0]  = '{1, 4, 6, 0, 6, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 4, 0, 1, 6, 6, 1, 0, 2, 0, 1, 1, 0};
        vecs[2]  = '{1, 4, 6, 1, 6, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[3]  = '{0, 4, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 4, 0, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[5]  = '{0, 4, 0, 1, 4, 0, 1, 0, 2, 0, 1, 0, 1};
        vecs[6]  = '{1, 6, 0, 0, 6, 0, 1, 0, 1, 1, 0, 0, 1};
        vecs[7]  = '{1, 5, 7, 0, 6, 0, 1, 0, 1, 1, 0, 0, 1};
        vecs[8]  = '{0, 4, 0, 1, 7, 2, 1, 0, 2, 0, 1, 1, 0};
        vecs[9]  = '{0, 4, 0, 0, 6, 0, 1, 1, 0, 0, 0, 0, 1};
        vecs[10] = '{0, 4, 0, 1, 6, 0, 1, 1, 2, 0, 1, 1, 1};
        vecs[11] = '{1, 5, 6, 1, 7, 6, 0, 0, 1, 0, 0, 0, 0};

        // Reset state
        doReset();
        @(negedge clock);
        chk("rst.c_valid", c_valid, 0);
        chk("rst.rel_pending", rel_pending, 0);
        chk("rst.err", err, 0);
        chk("rst.c_source", c_source, 0);

        // Single-message vectors, each from a fresh reset
        for (int i = 0; i < 12; i++) begin
            doReset();
            p_valid = vecs[i].pv; p_opcode = vecs[i].pop; p_size = vecs[i].psz;
            p_address = 32'hA000_0000 + 32'(i);
            r_valid = vecs[i].rv; r_opcode = vecs[i].rop; r_size = vecs[i].rsz;
            r_address = 32'hB000_0000 + 32'(i);
            c_ready = vecs[i].cr; d_relack = vecs[i].ack;
            @(negedge clock);
            chk($sformatf("v%0d.c_valid", i), c_valid, (vecs[i].src != 0));
            chk($sformatf("v%0d.p_ready", i), p_ready, vecs[i].pr);
            chk($sformatf("v%0d.r_ready", i), r_ready, vecs[i].rr);
            if (vecs[i].src == 2'd1) begin
                chk($sformatf("v%0d.c_opcode", i), c_opcode, vecs[i].pop);
                chk($sformatf("v%0d.c_address", i), c_address, 32'hA000_0000 + 32'(i));
            end else if (vecs[i].src == 2'd2) begin
                chk($sformatf("v%0d.c_opcode", i), c_opcode, vecs[i].rop);
                chk($sformatf("v%0d.c_address", i), c_address, 32'hB000_0000 + 32'(i));
            end
            tick();
            clearInputs();
            chk($sformatf("v%0d.rel_pending", i), rel_pending, vecs[i].relp);
            chk($sformatf("v%0d.err", i), err, vecs[i].er);
        end

        // ReleaseData of 16 beats, probe arrives at beat 3 but waits for the burst
        doReset();
        r_valid = 1; r_opcode = 3'd7; r_size = 4'd6; r_data = 32'd0; c_ready = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            chk($sformatf("relBurst%0d.c_valid", k), c_valid, 1);
            chk($sformatf("relBurst%0d.c_data", k), c_data, 32'(k));
            chk($sformatf("relBurst%0d.r_ready", k), r_ready, 1);
            chk($sformatf("relBurst%0d.p_ready", k), p_ready, 0);
            tick();
            r_data = 32'(k + 1);
            if (k == 1) p_valid = 1;
        end
        r_valid = 0;
        @(negedge clock);
        chk("relBurst.rel_pending", rel_pending, 1);
        chk("relBurst.p_granted", p_ready, 1);
        chk("relBurst.p_opcode", c_opcode, 4);
        tick();
        p_valid = 0;

        // Pending Release blocks the release requester until ReleaseAck
        r_valid = 1; r_opcode = 3'd6; r_size = 4'd0;
        @(negedge clock);
        chk("pend.r_ready", r_ready, 0);
        chk("pend.c_valid", c_valid, 0);
        tick();
        d_relack = 1;
        @(negedge clock);
        chk("ackCycle.r_ready", r_ready, 0);
        tick();
        d_relack = 0;
        @(negedge clock);
        chk("afterAck.rel_pending", rel_pending, 0);
        chk("afterAck.r_ready", r_ready, 1);
        chk("afterAck.c_opcode", c_opcode, 6);
        chk("afterAck.err", err, 0);
        tick();
        r_valid = 0;
        @(negedge clock);
        chk("afterAck.rel_pending_set", rel_pending, 1);

        // Probe streak fairness: P,P,P,P,R,P
        doReset();
        p_valid = 1; p_opcode = 3'd4; r_valid = 1; r_opcode = 3'd6; c_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("streak%0d.c_opcode", i), c_opcode, expOps[i]);
            tick();
        end

        // 8-beat ProbeAckData with c_ready toggling; pending release is locked out
        doReset();
        p_valid = 1; p_opcode = 3'd5; p_size = 4'd5; p_data = 32'd0;
        r_valid = 1; r_opcode = 3'd6; c_ready = 1;
        fires = 0;
        for (int cyc = 0; cyc < 40 && fires < 8; cyc++) begin
            @(negedge clock);
            chk("pBurst.r_ready", r_ready, 0);
            fireNow = c_valid && c_ready;
            if (fireNow) chk($sformatf("pBurst%0d.c_data", fires), c_data, 32'(fires));
            tick();
            if (fireNow) begin
                fires++;
                p_data = 32'(fires);
                if (fires == 8) p_valid = 0;
            end
            c_ready = ~c_ready;
        end
        chk("pBurst.fires", 32'(fires), 8);
        c_ready = 1;
        @(negedge clock);
        chk("pBurst.idle_r_ready", r_ready, 1);
        chk("pBurst.idle_c_opcode", c_opcode, 6);

        // Reset during beat 5 of a 16-beat ReleaseData
        doReset();
        r_valid = 1; r_opcode = 3'd7; r_size = 4'd6; c_ready = 1;
        for (int k = 0; k < 4; k++) tick();
        reset = 1;
        @(negedge clock);
        chk("midRst.c_valid", c_valid, 0);
        chk("midRst.r_ready", r_ready, 0);
        chk("midRst.p_ready", p_ready, 0);
        tick();
        reset = 0;
        r_valid = 0; p_valid = 1; p_opcode = 3'd4; p_size = 4'd0;
        @(negedge clock);
        chk("midRst.idle_p_ready", p_ready, 1);
        chk("midRst.rel_pending", rel_pending, 0);
        chk("midRst.err", err, 0);

        // Sticky error from a bad release opcode, cleared only by reset
        doReset();
        r_valid = 1; r_opcode = 3'd4; c_ready = 1;
        tick();
        r_valid = 0;
        tick();
        tick();
        @(negedge clock);
        chk("sticky.err", err, 1);
        doReset();
        @(negedge clock);
        chk("sticky.err_cleared", err, 0);
        d_relack = 1;
        tick();
        d_relack = 0;
        tick();
        @(negedge clock);
        chk("spuriousAck.err", err, 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
